// File: rtl/pwm_pkg.sv
// Shared register map and decode helpers for the
// multi-channel dead-time PWM block.
package pwm_pkg;

  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_PERIOD   = 1;
  localparam int unsigned ADDR_DEADTIME = 2;
  localparam int unsigned ADDR_DUTY0    = 3;

  localparam int unsigned CTRL_EN = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_PERIOD,
    SEL_DT,
    SEL_DUTY
  } reg_sel_e;

  function automatic reg_sel_e reg_decode(
    input int unsigned addr,
    input int unsigned num_ch
  );
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr == ADDR_CTRL) begin
      sel = SEL_CTRL;
    end else if (addr == ADDR_PERIOD) begin
      sel = SEL_PERIOD;
    end else if (addr == ADDR_DEADTIME) begin
      sel = SEL_DT;
    end else if (addr >= ADDR_DUTY0 &&
                 addr < ADDR_DUTY0 + num_ch) begin
      sel = SEL_DUTY;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pwm_multi_dt_deadtime.sv
// Per-channel dead-time inserter: turns the raw PWM
// level into a registered, never-overlapping hi/lo pair.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            raw_i,
  input  logic [DT_W-1:0] dt_i,
  output logic            hi_o,
  output logic            lo_o
);

  logic            raw_q, raw_d;
  logic [DT_W-1:0] dcnt_q, dcnt_d;
  logic            hi_q, hi_d;
  logic            lo_q, lo_d;

  logic off, chg, run, idle;

  assign off  = !en_i;
  assign chg  = en_i && (raw_i != raw_q);
  assign run  = en_i && (raw_i == raw_q) &&
                (dcnt_q != '0);
  assign idle = en_i && (raw_i == raw_q) &&
                (dcnt_q == '0);

  always_comb begin
    raw_d  = raw_q;
    dcnt_d = dcnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    unique case (1'b1)
      off: begin
        raw_d  = 1'b0;
        dcnt_d = '0;
        hi_d   = 1'b0;
        lo_d   = 1'b0;
      end
      chg: begin
        raw_d = raw_i;
        if (dt_i == '0) begin
          dcnt_d = '0;
          hi_d   = raw_i;
          lo_d   = !raw_i;
        end else begin
          dcnt_d = dt_i;
          hi_d   = 1'b0;
          lo_d   = 1'b0;
        end
      end
      run: begin
        dcnt_d = dcnt_q - DT_W'(1);
        // the gap ends on the edge that empties the counter
        if (dcnt_q == DT_W'(1)) begin
          hi_d = raw_i;
          lo_d = !raw_i;
        end
      end
      idle: begin
        hi_d = raw_i;
        lo_d = !raw_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raw_q  <= 1'b0;
      dcnt_q <= '0;
      hi_q   <= 1'b0;
      lo_q   <= 1'b0;
    end else begin
      raw_q  <= raw_d;
      dcnt_q <= dcnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/pwm_multi_dt.sv
// Avalon-MM multi-channel PWM with double-buffered
// period/duty, shared counter and per-channel dead-time.
module pwm_multi_dt
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int DT_W   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              csi_clk,
  input  logic              csi_reset_n,
  input  logic              avs_chipselect,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] coe_pwm_hi,
  output logic [NUM_CH-1:0] coe_pwm_lo
);

  logic             en_q, en_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [DT_W-1:0]  dt_q, dt_d;
  logic [CNT_W-1:0] duty_q [NUM_CH];
  logic [CNT_W-1:0] duty_d [NUM_CH];
  logic             upd_q, upd_d;

  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [DT_W-1:0]  dt_sh_q, dt_sh_d;
  logic [CNT_W-1:0] duty_sh_q [NUM_CH];
  logic [CNT_W-1:0] duty_sh_d [NUM_CH];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic              wr, rd, load, wrap;
  reg_sel_e          sel;
  logic [NUM_CH-1:0] duty_hit;
  logic [CNT_W-1:0]  duty_rd;
  logic [NUM_CH-1:0] raw;
  logic              dt_en;
  logic              unused_wd;

  assign wr  = avs_chipselect && avs_write;
  assign rd  = avs_chipselect && avs_read;
  assign sel = reg_decode(32'(avs_address),
                          NUM_CH);
  assign unused_wd = ^avs_writedata;

  always_comb begin
    duty_hit = '0;
    duty_rd  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (avs_address ==
          ADDR_W'(ADDR_DUTY0 + k)) begin
        duty_hit[k] = 1'b1;
        duty_rd     = duty_q[k];
      end
    end
  end

  assign wrap = (cnt_q == period_sh_q);

  // shadows refresh on enable, or at period end if dirty
  assign load = (!en_q && en_d) ||
                (en_q && wrap && upd_q);

  always_comb begin
    en_d     = en_q;
    period_d = period_q;
    dt_d     = dt_q;
    duty_d   = duty_q;
    upd_d    = upd_q;
    if (wr && sel == SEL_CTRL) begin
      en_d = avs_writedata[CTRL_EN];
    end
    if (wr && sel == SEL_PERIOD) begin
      period_d = avs_writedata[CNT_W-1:0];
    end
    if (wr && sel == SEL_DT) begin
      dt_d = avs_writedata[DT_W-1:0];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr && sel == SEL_DUTY && duty_hit[k]) begin
        duty_d[k] = avs_writedata[CNT_W-1:0];
      end
    end
    if (load) begin
      upd_d = 1'b0;
    end
    if (wr && (sel == SEL_PERIOD ||
               sel == SEL_DUTY)) begin
      upd_d = 1'b1;
    end
  end

  always_comb begin
    period_sh_d = period_sh_q;
    dt_sh_d     = dt_sh_q;
    duty_sh_d   = duty_sh_q;
    if (load) begin
      period_sh_d = period_q;
      dt_sh_d     = dt_q;
      for (int k = 0; k < NUM_CH; k++) begin
        duty_sh_d[k] = duty_q[k];
      end
    end
  end

  always_comb begin
    if (!en_q || !en_d || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      unique case (sel)
        SEL_CTRL:   rdata_d[CTRL_EN] = en_q;
        SEL_PERIOD: rdata_d[CNT_W-1:0] = period_q;
        SEL_DT:     rdata_d[DT_W-1:0] = dt_q;
        SEL_DUTY:   rdata_d[CNT_W-1:0] = duty_rd;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge csi_clk) begin
    if (!csi_reset_n) begin
      en_q        <= 1'b0;
      period_q    <= '0;
      dt_q        <= '0;
      upd_q       <= 1'b0;
      period_sh_q <= '0;
      dt_sh_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        duty_q[k]    <= '0;
        duty_sh_q[k] <= '0;
      end
    end else begin
      en_q        <= en_d;
      period_q    <= period_d;
      dt_q        <= dt_d;
      upd_q       <= upd_d;
      period_sh_q <= period_sh_d;
      dt_sh_q     <= dt_sh_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      for (int k = 0; k < NUM_CH; k++) begin
        duty_q[k]    <= duty_d[k];
        duty_sh_q[k] <= duty_sh_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      raw[k] = en_q && (cnt_q < duty_sh_q[k]);
    end
  end

  // clear the pairs on the edge that disables counting
  assign dt_en = en_q && en_d;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk_i (csi_clk),
      .rst_ni(csi_reset_n),
      .en_i  (dt_en),
      .raw_i (raw[k]),
      .dt_i  (dt_sh_q),
      .hi_o  (coe_pwm_hi[k]),
      .lo_o  (coe_pwm_lo[k])
    );
  end

  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_pwm_multi_dt.sv
// Directed bench for pwm_multi_dt: waveform shape,
// dead-time, double buffering, extremes and bus access.
module tb_pwm_multi_dt;

  localparam int NCH = 4;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic cs, wr, rd;
  logic [3:0] addr;
  logic [31:0] wdata, rdata;
  logic [NCH-1:0] hi, lo;

  int passes = 0;
  int total = 0;
  int cyc = 0;
  int base = 0;
  logic [31:0] rv;

  logic [NCH-1:0] hi_a [DEPTH];
  logic [NCH-1:0] lo_a [DEPTH];

  pwm_multi_dt #(
    .NUM_CH(NCH),
    .CNT_W (16),
    .DT_W  (8),
    .ADDR_W(4)
  ) dut (
    .csi_clk       (clk),
    .csi_reset_n   (rst_n),
    .avs_chipselect(cs),
    .avs_address   (addr),
    .avs_write     (wr),
    .avs_writedata (wdata),
    .avs_read      (rd),
    .avs_readdata  (rdata),
    .coe_pwm_hi    (hi),
    .coe_pwm_lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (cyc < DEPTH) begin
      hi_a[cyc] = hi;
      lo_a[cyc] = lo;
    end
    chk("overlap", 32'(hi & lo), 32'd0);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_reg(input logic [3:0] a,
                        input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a,
                        output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  function automatic int nhi(input int ch,
                             input int a,
                             input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(hi_a[base+i][ch]);
    return n;
  endfunction

  function automatic int nlo(input int ch,
                             input int a,
                             input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(lo_a[base+i][ch]);
    return n;
  endfunction

  function automatic logic hat(input int ch,
                               input int r);
    return hi_a[base+r][ch];
  endfunction

  function automatic logic lat(input int ch,
                               input int r);
    return lo_a[base+r][ch];
  endfunction

  initial begin
    rst_n = 1'b0;
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst hi", 32'(hi), 32'd0);
    chk("rst lo", 32'(lo), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    rd_reg(4'd0, rv);
    chk("rst ctrl", rv, 32'd0);

    // basic duty, DT=0
    wr_reg(4'd1, 32'd9);
    wr_reg(4'd3, 32'd3);
    wr_reg(4'd4, 32'd0);
    wr_reg(4'd5, 32'd10);
    wr_reg(4'd6, 32'd4);
    wr_reg(4'd2, 32'd0);
    wr_reg(4'd0, 32'd1);
    base = cyc;
    run(30);
    chk("A hi0 c0", 32'(hat(0, 0)), 32'd0);
    chk("A hi0 c1", 32'(hat(0, 1)), 32'd1);
    chk("A hi0 cnt", 32'(nhi(0, 10, 19)), 32'd3);
    chk("A lo0 cnt", 32'(nlo(0, 10, 19)), 32'd7);
    chk("A hi1 cnt", 32'(nhi(1, 10, 19)), 32'd0);
    chk("A lo1 cnt", 32'(nlo(1, 10, 19)), 32'd10);
    chk("A hi2 cnt", 32'(nhi(2, 10, 19)), 32'd10);
    chk("A lo2 cnt", 32'(nlo(2, 10, 19)), 32'd0);
    chk("A hi3 cnt", 32'(nhi(3, 10, 19)), 32'd4);
    chk("A lo3 cnt", 32'(nlo(3, 10, 19)), 32'd6);

    // disable at cnt=5
    run(5);
    chk("A lo0 c35", 32'(lo[0]), 32'd1);
    chk("A hi2 c35", 32'(hi[2]), 32'd1);
    wr_reg(4'd0, 32'd0);
    chk("dis hi", 32'(hi), 32'd0);
    chk("dis lo", 32'(lo), 32'd0);
    run(3);
    chk("dis hi hold", 32'(hi), 32'd0);
    chk("dis lo hold", 32'(lo), 32'd0);

    // dead-time 2
    wr_reg(4'd2, 32'd2);
    wr_reg(4'd0, 32'd1);
    base = cyc;
    run(30);
    chk("B hi0 c2", 32'(hat(0, 2)), 32'd0);
    chk("B hi0 c3", 32'(hat(0, 3)), 32'd1);
    chk("B hi0 c4", 32'(hat(0, 4)), 32'd0);
    chk("B lo0 c5", 32'(lat(0, 5)), 32'd0);
    chk("B lo0 c6", 32'(lat(0, 6)), 32'd1);
    chk("B hi0 cnt", 32'(nhi(0, 10, 19)), 32'd1);
    chk("B lo0 cnt", 32'(nlo(0, 10, 19)), 32'd5);
    chk("B hi3 cnt", 32'(nhi(3, 10, 19)), 32'd2);
    chk("B lo3 cnt", 32'(nlo(3, 10, 19)), 32'd4);
    chk("B lo1 cnt", 32'(nlo(1, 10, 19)), 32'd10);
    chk("B hi2 c2", 32'(hat(2, 2)), 32'd0);
    chk("B hi2 c3", 32'(hat(2, 3)), 32'd1);

    // double buffering: DUTY0 3 -> 6 at cnt=4
    run(4);
    wr_reg(4'd3, 32'd6);
    rd_reg(4'd3, rv);
    chk("C duty0 rb", rv, 32'd6);
    run(20);
    chk("C hi0 cur", 32'(nhi(0, 30, 39)), 32'd1);
    chk("C hi0 c42", 32'(hat(0, 42)), 32'd0);
    chk("C hi0 c43", 32'(hat(0, 43)), 32'd1);
    chk("C hi0 next", 32'(nhi(0, 40, 49)), 32'd4);

    // dead-time 5: short segments vanish
    wr_reg(4'd0, 32'd0);
    wr_reg(4'd2, 32'd5);
    wr_reg(4'd0, 32'd1);
    base = cyc;
    run(30);
    chk("D hi3 never", 32'(nhi(3, 0, 29)), 32'd0);
    chk("D lo3 cnt", 32'(nlo(3, 0, 29)), 32'd2);
    chk("D hi2 c5", 32'(hat(2, 5)), 32'd0);
    chk("D hi2 c6", 32'(hat(2, 6)), 32'd1);
    chk("D hi0 c6", 32'(hat(0, 6)), 32'd1);
    chk("D hi0 c7", 32'(hat(0, 7)), 32'd0);

    // reset mid-period
    run(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("E rst hi", 32'(hi), 32'd0);
    chk("E rst lo", 32'(lo), 32'd0);
    chk("E rst rdata", rdata, 32'd0);
    rd_reg(4'd1, rv);
    chk("E period", rv, 32'd0);
    rd_reg(4'd3, rv);
    chk("E duty0", rv, 32'd0);
    run(5);
    chk("E hi idle", 32'(hi), 32'd0);
    chk("E lo idle", 32'(lo), 32'd0);

    // bus widths, unmapped space, read latency
    wr_reg(4'd1, 32'hFFFF_FFFF);
    rd_reg(4'd1, rv);
    chk("F period w", rv, 32'h0000_FFFF);
    cs = 1'b1; rd = 1'b1; addr = 4'd7;
    chk("F rd before", rdata, 32'h0000_FFFF);
    tick();
    cs = 1'b0; rd = 1'b0;
    chk("F unmapped", rdata, 32'd0);
    wr_reg(4'd2, 32'h0000_01FF);
    rd_reg(4'd2, rv);
    chk("F dt w", rv, 32'h0000_00FF);
    run(3);
    chk("F rd hold", rdata, 32'h0000_00FF);
    wr_reg(4'd15, 32'h5555_5555);
    rd_reg(4'd15, rv);
    chk("F unm wr", rv, 32'd0);
    rd_reg(4'd1, rv);
    chk("F period kept", rv, 32'h0000_FFFF);
    wr_reg(4'd0, 32'hFFFF_FFFF);
    rd_reg(4'd0, rv);
    chk("F ctrl w", rv, 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
